// File: rtl/memory_arbiter.sv
// Purpose : single-CPU memory controller; arbitrates instruction fetches and data
//           reads/writes from the cache block onto one shared RAM port.
// Latency : request seen in IDLE at edge 0, strobes from cycle 1, completion on the
//           first cycle ramstate=ACCESS; one IDLE bubble follows every completion.
// Backpressure: requesters stall on iwait/dwait=1; the RAM stalls us with FREE/BUSY/ERROR.
//
// Ports:
//   CLK, nRST                    clock (rising edge), async active-low reset
//   iREN, iaddr                  instruction read request + address
//   dREN, dWEN, daddr, dstore    data read/write request, address, store value
//   iwait/iload, dwait/dload     per-side stall and load data (load valid when wait=0)
//   ramREN, ramWEN, ramaddr,
//   ramstore, ramload, ramstate  shared RAM port (ramstate 0=FREE 1=BUSY 2=ACCESS 3=ERROR)
//
// Optional build macro MEMARB_FAIRNESS_EN: after STARVE_LIMIT data completions with
// iREN pending, the next arbitration decision goes to the instruction side.
// Without it the data side always wins and no counter exists.

module memory_arbiter #(
    parameter int WORD_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    // instruction side
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    // data side
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    // RAM port
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    // A starvation limit of zero would lock out the data side entirely.
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("memory_arbiter: STARVE_LIMIT must be at least 1");
    end

    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DGRANT = 2'd1,
        ST_IGRANT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic w_d_req;
    logic w_access;
    logic w_d_done;
    logic w_force_i;

    assign w_d_req  = dREN | dWEN;
    assign w_access = (ramstate == RAM_ACCESS);
    // A data completion needs the request still present; a dropped request is an abort.
    assign w_d_done = (r_state == ST_DGRANT) && w_d_req && w_access;

`ifdef MEMARB_FAIRNESS_EN
    localparam int                CNT_W     = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_starve_cnt;

    assign w_force_i = iREN && (r_starve_cnt >= CNT_LIMIT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_starve_cnt <= '0;
        end else if (r_state == ST_IGRANT && w_next_state != ST_IGRANT) begin
            // leaving an instruction grant (completion or abort) repays the debt
            r_starve_cnt <= '0;
        end else if (r_state == ST_IDLE && !iREN) begin
            r_starve_cnt <= '0;
        end else if (w_d_done && iREN && r_starve_cnt != CNT_MAX) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    assign w_force_i = 1'b0;
`endif

    // State register: the only arbitration memory.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and all outputs. Outputs depend only on r_state and live inputs,
    // so the async reset forcing r_state to IDLE sets them immediately.
    always_comb begin
        w_next_state = r_state;
        iwait        = 1'b1;
        dwait        = 1'b1;
        iload        = '0;
        dload        = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_force_i) begin
                    w_next_state = ST_IGRANT;
                end else if (w_d_req) begin
                    w_next_state = ST_DGRANT;
                end else if (iREN) begin
                    w_next_state = ST_IGRANT;
                end
            end

            ST_DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!w_d_req) begin
                    // both requests withdrawn: strobes stay low, no completion
                    w_next_state = ST_IDLE;
                end else begin
                    ramWEN = dWEN;
                    ramREN = dREN & ~dWEN;  // write wins when both are raised
                    if (w_access) begin
                        dwait        = 1'b0;
                        dload        = dWEN ? '0 : ramload;
                        w_next_state = ST_IDLE;
                    end
                    // FREE/BUSY hold; ERROR keeps strobes up so the RAM retries
                end
            end

            ST_IGRANT: begin
                ramaddr = iaddr;
                if (!iREN) begin
                    w_next_state = ST_IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (w_access) begin
                        iwait        = 1'b0;
                        iload        = ramload;
                        w_next_state = ST_IDLE;
                    end
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Purpose : directed bench for memory_arbiter with a completion scoreboard.
// Latency : stimulus drives 1 time unit after the rising edge, all sampling on the falling edge.
// Backpressure: RAM behaviour is scripted per cycle through ramstate.

module tb_memory_arbiter;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

`ifdef MEMARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        CLK;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    memory_arbiter #(.WORD_W(32), .STARVE_LIMIT(4)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic        is_d;
        logic [31:0] addr;
        logic [31:0] load;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push_exp(input logic is_d, input logic [31:0] addr, input logic [31:0] load);
        exp_t e;
        e.is_d = is_d;
        e.addr = addr;
        e.load = load;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Compare RAM port and wait flags against hand-computed values, right now.
    task automatic cmp_now(input string name, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] store,
                           input logic iw, input logic dw);
        logic [67:0] got;
        logic [67:0] want;
        got  = {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait};
        want = {ren, wen, addr, store, iw, dw};
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got ren=%b wen=%b addr=%h store=%h iwait=%b dwait=%b, want ren=%b wen=%b addr=%h store=%h iwait=%b dwait=%b",
                     name, ramREN, ramWEN, ramaddr, ramstore, iwait, dwait,
                     ren, wen, addr, store, iw, dw);
        end
    endtask

    task automatic chk(input string name, input logic ren, input logic wen,
                       input logic [31:0] addr, input logic [31:0] store,
                       input logic iw, input logic dw);
        @(negedge CLK);
        cmp_now(name, ren, wen, addr, store, iw, dw);
    endtask

    // Scoreboard monitor: every completion pulse pops one expected transaction.
    initial begin
        exp_t        e;
        logic        got_d;
        logic [31:0] got_load;
        forever begin
            @(negedge CLK);
            if (nRST === 1'b1) begin
                if (iwait === 1'b0 && dwait === 1'b0) begin
                    n_err++;
                    $display("FAIL both_waits_low: iwait=%b dwait=%b, want never both 0", iwait, dwait);
                end
                if (iwait !== 1'b0 && iload !== 32'h0) begin
                    n_err++;
                    $display("FAIL iload_while_wait: iload=%h, want 0", iload);
                end
                if (dwait !== 1'b0 && dload !== 32'h0) begin
                    n_err++;
                    $display("FAIL dload_while_wait: dload=%h, want 0", dload);
                end
                if (iwait === 1'b0 || dwait === 1'b0) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_completion: iwait=%b dwait=%b addr=%h, want no completion",
                                 iwait, dwait, ramaddr);
                    end else begin
                        e        = exp_q.pop_front();
                        got_d    = (dwait === 1'b0);
                        got_load = got_d ? dload : iload;
                        if (got_d !== e.is_d || ramaddr !== e.addr || got_load !== e.load) begin
                            n_err++;
                            $display("FAIL completion: got side=%s addr=%h load=%h, want side=%s addr=%h load=%h",
                                     got_d ? "D" : "I", ramaddr, got_load,
                                     e.is_d ? "D" : "I", e.addr, e.load);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST     = 1'b1;
        iREN     = 1'b0;
        iaddr    = '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        ramload  = '0;
        ramstate = RS_FREE;

        // ---- reset with requests and ACCESS held ----
        #1;
        nRST     = 1'b0;
        iREN     = 1'b1;
        dREN     = 1'b1;
        daddr    = 32'h10;
        iaddr    = 32'h20;
        ramload  = 32'hA5A5A5A5;
        ramstate = RS_ACCESS;
        #1;
        cmp_now("reset_immediate", 0, 0, 32'h0, 32'h0, 1, 1);
        chk("reset_held", 0, 0, 32'h0, 32'h0, 1, 1);
        n_vec++;
        if (iload !== 32'h0 || dload !== 32'h0) begin
            n_err++;
            $display("FAIL reset_loads: iload=%h dload=%h, want 0 0", iload, dload);
        end
        tick();
        nRST = 1'b1;
        chk("release_idle", 0, 0, 32'h0, 32'h0, 1, 1);
        tick();
        push_exp(1'b1, 32'h10, 32'hA5A5A5A5);
        chk("first_strobe", 1, 0, 32'h10, 32'h0, 1, 0);
        tick();
        dREN = 1'b0; iREN = 1'b0; ramstate = RS_FREE;
        chk("t1_idle", 0, 0, 32'h0, 32'h0, 1, 1);

        // ---- data read, ACCESS on 3rd strobe cycle ----
        tick();
        dREN = 1'b1; daddr = 32'h100; ramload = 32'hDEADBEEF; ramstate = RS_BUSY;
        chk("t2_idle", 0, 0, 32'h0, 32'h0, 1, 1);
        tick();
        chk("t2_busy1", 1, 0, 32'h100, 32'h0, 1, 1);
        tick();
        chk("t2_busy2", 1, 0, 32'h100, 32'h0, 1, 1);
        tick();
        ramstate = RS_ACCESS;
        push_exp(1'b1, 32'h100, 32'hDEADBEEF);
        chk("t2_access", 1, 0, 32'h100, 32'h0, 1, 0);
        tick();
        dREN = 1'b0; ramstate = RS_FREE;
        chk("t2_after", 0, 0, 32'h0, 32'h0, 1, 1);

        // ---- simultaneous iREN + dWEN, 1-cycle RAM ----
        tick();
        iREN = 1'b1; iaddr = 32'h200; dWEN = 1'b1; daddr = 32'h40; dstore = 32'h12345678;
        ramload = 32'h0BADF00D; ramstate = RS_ACCESS;
        push_exp(1'b1, 32'h40, 32'h0);
        push_exp(1'b0, 32'h200, 32'h0BADF00D);
        chk("t3_idle", 0, 0, 32'h0, 32'h0, 1, 1);
        tick();
        chk("t3_dwrite", 0, 1, 32'h40, 32'h12345678, 1, 0);
        tick();
        dWEN = 1'b0; dstore = 32'h0;
        chk("t3_bubble", 0, 0, 32'h0, 32'h0, 1, 1);
        tick();
        chk("t3_ifetch", 1, 0, 32'h200, 32'h0, 0, 1);
        tick();
        iREN = 1'b0; ramstate = RS_FREE;
        chk("t3_after", 0, 0, 32'h0, 32'h0, 1, 1);

        // ---- dREN during an in-flight IGRANT, 4 BUSY cycles ----
        tick();
        iREN = 1'b1; iaddr = 32'h300; ramstate = RS_BUSY;
        tick();
        dREN = 1'b1; daddr = 32'h500;
        chk("t4_ig_busy1", 1, 0, 32'h300, 32'h0, 1, 1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("t4_ig_busy", 1, 0, 32'h300, 32'h0, 1, 1);
        end
        tick();
        ramstate = RS_ACCESS; ramload = 32'h11111111;
        push_exp(1'b0, 32'h300, 32'h11111111);
        chk("t4_ig_access", 1, 0, 32'h300, 32'h0, 0, 1);
        tick();
        iREN = 1'b0; ramload = 32'h22222222;
        push_exp(1'b1, 32'h500, 32'h22222222);
        chk("t4_bubble", 0, 0, 32'h0, 32'h0, 1, 1);
        tick();
        chk("t4_dgrant", 1, 0, 32'h500, 32'h0, 1, 0);
        tick();
        dREN = 1'b0; ramstate = RS_FREE;
        chk("t4_after", 0, 0, 32'h0, 32'h0, 1, 1);

        // ---- ERROR retry on a data read ----
        tick();
        dREN = 1'b1; daddr = 32'h600; ramload = 32'h33333333; ramstate = RS_ERROR;
        tick();
        chk("t5_err1", 1, 0, 32'h600, 32'h0, 1, 1);
        tick();
        chk("t5_err2", 1, 0, 32'h600, 32'h0, 1, 1);
        tick();
        ramstate = RS_ACCESS;
        push_exp(1'b1, 32'h600, 32'h33333333);
        chk("t5_access", 1, 0, 32'h600, 32'h0, 1, 0);
        tick();
        dREN = 1'b0; ramstate = RS_FREE;
        chk("t5_after", 0, 0, 32'h0, 32'h0, 1, 1);

        // ---- abort: dREN drops mid-BUSY ----
        tick();
        dREN = 1'b1; daddr = 32'h700; ramstate = RS_BUSY;
        tick();
        chk("t6_busy", 1, 0, 32'h700, 32'h0, 1, 1);
        tick();
        dREN = 1'b0;
        chk("t6_abort", 0, 0, 32'h700, 32'h0, 1, 1);
        tick();
        chk("t6_idle", 0, 0, 32'h0, 32'h0, 1, 1);

        // ---- reset mid-transaction abandons it ----
        tick();
        dREN = 1'b1; daddr = 32'h780;
        tick();
        chk("t7_busy", 1, 0, 32'h780, 32'h0, 1, 1);
        #2;
        nRST = 1'b0;
        #1;
        cmp_now("t7_reset_mid", 0, 0, 32'h0, 32'h0, 1, 1);
        ramstate = RS_ACCESS;
        tick();
        dREN = 1'b0;
        tick();
        nRST = 1'b1; ramstate = RS_FREE;
        chk("t7_after_reset", 0, 0, 32'h0, 32'h0, 1, 1);

        // ---- both sides held continuously, 1-cycle RAM ----
        for (int k = 0; k < 10; k++) begin
            if (FAIR && (k % 5) == 4)
                push_exp(1'b0, 32'h900, 32'h44444444);
            else
                push_exp(1'b1, 32'h800, 32'h44444444);
        end
        tick();
        dREN = 1'b1; daddr = 32'h800; iREN = 1'b1; iaddr = 32'h900;
        ramload = 32'h44444444; ramstate = RS_ACCESS;
        repeat (20) tick();
        dREN = 1'b0; iREN = 1'b0; ramstate = RS_FREE;
        chk("t8_final_idle", 0, 0, 32'h0, 32'h0, 1, 1);
        tick();

        @(negedge CLK);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drained: %0d completions outstanding, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Single-CPU memory controller: the responder end of the cache-control interface.
- Accepts instruction-fetch requests (iREN/iaddr) and data requests (dREN/dWEN/daddr/dstore) from the cache block, arbitrates them onto one shared RAM port, and returns iwait/dwait/iload/dload.
- Sits between the caches and the RAM model/bus. One RAM transaction in flight at a time.

Parameters:
- WORD_W, 32, width of addresses, store data and load data.
- STARVE_LIMIT, 4, consecutive data grants with iREN pending before the instruction side is forced (only with the optional feature).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  WORD_W  instruction address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  WORD_W  data address.
- dstore  in  WORD_W  data write value.
- iwait  out  1  instruction side stalled; low for exactly the completion cycle.
- dwait  out  1  data side stalled; low for exactly the completion cycle.
- iload  out  WORD_W  instruction read data, valid when iwait=0.
- dload  out  WORD_W  data read data, valid when dwait=0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR.

Behaviour:
- Reset (async, nRST=0):
  - FSM forced to IDLE; starvation counter cleared.
  - Output values: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - Outputs take these values immediately on assertion, not at the next edge.
  - Reset mid-transaction abandons the transaction; no completion is signalled.
- FSM states: IDLE, DGRANT, IGRANT. The state register is the only arbitration memory.
- IDLE:
  - No RAM strobes; iwait=dwait=1.
  - Next state: DGRANT if (dREN|dWEN), else IGRANT if iREN, else IDLE.
  - The data side wins simultaneous requests.
- DGRANT:
  - ramaddr=daddr; ramstore=dstore.
  - ramWEN=dWEN; ramREN=dREN&~dWEN (write wins if both are asserted).
  - On ramstate=ACCESS: dwait=0 and dload=ramload for that cycle (dload=0 on writes), then go to IDLE.
  - FREE/BUSY: hold.
  - ERROR: dwait stays 1, strobes stay asserted (retry), remain in DGRANT.
  - If dREN and dWEN both drop before ACCESS: abort; strobes deassert in the same cycle, go to IDLE, no dwait pulse.
- IGRANT:
  - Same as DGRANT with iaddr/iREN/iwait/iload; ramWEN=0 always.
  - A data request arriving mid-IGRANT waits; grants are never pre-empted.
- Wait/load signals:
  - iwait and dwait are never low in the same cycle.
  - The ungranted side's wait is always 1.
  - iload and dload are 0 whenever the respective wait is 1.
- Timing and stability:
  - Minimum latency is 2 edges: request seen in IDLE at edge 0, strobes in cycle 1, earliest completion in cycle 1 if RAM returns ACCESS combinationally.
  - After every completion the FSM passes through IDLE for one cycle; no back-to-back strobes.
  - Requesters hold address/data stable while their wait=1. RAM signals are driven combinationally from the live inputs during the grant.

Optional Feature:
- Macro: MEMARB_FAIRNESS_EN.
- With the macro defined:
  - A 3-bit-saturating counter (clog2(STARVE_LIMIT)+1 bits) increments on each data completion while iREN=1.
  - The counter clears on any instruction completion, or when iREN=0 in IDLE.
  - When the counter reaches STARVE_LIMIT, IDLE chooses IGRANT even if a data request is pending.
  - The counter clears after that grant.
- Without the macro: strict data priority; no counter logic is present.

Test Plan:
- Reset with iREN=dREN=1 and RAM ACCESS held -> iwait=dwait=1, strobes 0, all data outputs 0 during reset. First strobe (ramWEN/ramREN=1 for data) appears one cycle after release.
- dREN=1, daddr=0x100, RAM answers ACCESS on the 3rd strobe cycle with ramload=0xDEADBEEF -> ramREN=1/ramaddr=0x100 for 3 cycles, dwait=0 and dload=0xDEADBEEF for exactly one cycle, then IDLE.
- iREN and dWEN asserted together, daddr=0x40, dstore=0x12345678, 1-cycle RAM -> data write completes first (ramWEN=1, ramstore=0x12345678), IDLE bubble, then ramREN with iaddr, iwait=0 one cycle.
- dREN during an in-flight IGRANT with RAM BUSY for 4 cycles -> no switch; iwait=0 on ACCESS, then DGRANT follows after one IDLE cycle.
- ramstate=ERROR for 2 cycles then ACCESS during a data read -> strobes held throughout, dwait=0 only on the ACCESS cycle. Drop dREN mid-BUSY in a separate run -> strobes fall the same cycle, no dwait pulse.
- MEMARB_FAIRNESS_EN, STARVE_LIMIT=4, dREN and iREN both held continuously -> 4 data completions, then 1 instruction completion, repeating. Without the macro -> iwait never low.
